// File: rtl/interleaver_seq_gen.sv
// Runtime-programmable activation-address generator for one sparse junction.
// Walks all FO*P/Z cycles and streams Z packed act-memory addresses per beat.
module interleaver_seq_gen #(
  parameter int unsigned FO = 2,
  parameter int unsigned P  = 32,
  parameter int unsigned Z  = 8,
  localparam int unsigned NCYC  = FO * P / Z,
  localparam int unsigned CW    = $clog2(NCYC),
  localparam int unsigned SW    = $clog2(P / Z),
  localparam int unsigned AW    = $clog2(P),
  localparam int unsigned ZW    = $clog2(Z),
  localparam int unsigned DEPTH = FO * Z,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             ss_we,
  input  logic [IW-1:0]    ss_waddr,
  input  logic [SW-1:0]    ss_wdata,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [AW*Z-1:0]  out_index_pkg,
  output logic [CW-1:0]    out_cycle,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ss_wr_err
);

  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_d;
  logic [SW-1:0]     ss_tab [DEPTH];
  logic [SW-1:0]     ss_eff [DEPTH];
  logic              waddr_ok;
  logic              load;
  logic              valid_d, last_d, busy_d, done_d, err_d;
  logic [CW-1:0]     cyc_d;
  logic [AW*Z-1:0]   pkg_d, addr_c;
  logic [CW-1:0]     sweep;
  logic [SW-1:0]     grp, ent, tt;
  int                idx;

  // Full-size tables need no range check on the write index.
  if (DEPTH == (1 << IW)) begin : g_full
    assign waddr_ok = 1'b1;
  end else begin : g_part
    assign waddr_ok = (ss_waddr < IW'(DEPTH));
  end

  // Next-state, next-beat and table-forwarding logic.
  always_comb begin
    state_d = state;
    valid_d = out_valid;
    cyc_d   = out_cycle;
    pkg_d   = out_index_pkg;
    load    = 1'b0;
    ss_eff  = ss_tab;
    if (state == S_IDLE && ss_we && waddr_ok)
      ss_eff[ss_waddr] = ss_wdata;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          cyc_d   = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (out_valid && out_ready) begin
          if (out_cycle == LAST && !cont) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end else begin
            cyc_d = (out_cycle == LAST) ? '0 : out_cycle + CW'(1);
            load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Lane j of cycle c: rotate the sweep-start entry by the group offset.
    addr_c = '0;
    sweep  = cyc_d >> SW;
    grp    = cyc_d[SW-1:0];
    ent    = '0;
    tt     = '0;
    idx    = 0;
    for (int j = 0; j < int'(Z); j++) begin
      idx = int'(sweep) * int'(Z) + j;
      ent = (idx < int'(DEPTH)) ? ss_eff[IW'(idx)] : '0;
      tt  = SW'(ent + grp);
      addr_c[AW*j +: AW] = {tt, ZW'(j)};
    end
    if (load)
      pkg_d = addr_c;

    last_d = valid_d && (cyc_d == LAST);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = ss_we && (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      out_valid     <= 1'b0;
      out_cycle     <= '0;
      out_index_pkg <= '0;
      out_last      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ss_wr_err     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++)
        ss_tab[i] <= '0;
    end else begin
      state         <= state_d;
      out_valid     <= valid_d;
      out_cycle     <= cyc_d;
      out_index_pkg <= pkg_d;
      out_last      <= last_d;
      busy          <= busy_d;
      done          <= done_d;
      ss_wr_err     <= err_d;
      ss_tab        <= ss_eff;
    end
  end

endmodule

// File: tb/tb_interleaver_seq_gen.sv
// Directed bench for interleaver_seq_gen at FO=2, P=32, Z=8 (8 cycles per pass).
module tb_interleaver_seq_gen;

  logic        clk = 1'b0;
  logic        reset, start, cont, ss_we, out_ready;
  logic [3:0]  ss_waddr;
  logic [1:0]  ss_wdata;
  logic        out_valid, out_last, busy, done, ss_wr_err;
  logic [39:0] out_index_pkg;
  logic [2:0]  out_cycle;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  logic [1:0]  tab [16];
  logic [39:0] ident, lanes8;

  interleaver_seq_gen #(.FO(2), .P(32), .Z(8)) dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont),
    .ss_we(ss_we), .ss_waddr(ss_waddr), .ss_wdata(ss_wdata),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_index_pkg(out_index_pkg), .out_cycle(out_cycle),
    .out_last(out_last), .busy(busy), .done(done), .ss_wr_err(ss_wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference address set for cycle c from the bench's own copy of the table.
  function automatic logic [39:0] model(input int c);
    logic [39:0] r;
    int s, g, t;
    r = '0;
    s = c / 4;
    g = c % 4;
    for (int j = 0; j < 8; j++) begin
      t = (int'(tab[s*8+j]) + g) % 4;
      r[5*j +: 5] = 5'(t * 8 + j);
    end
    return r;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input int c);
    chk($sformatf("%s c%0d valid", tag, c), 64'(out_valid), 64'(1));
    chk($sformatf("%s c%0d cycle", tag, c), 64'(out_cycle), 64'(c));
    chk($sformatf("%s c%0d pkg", tag, c), 64'(out_index_pkg), 64'(model(c)));
    chk($sformatf("%s c%0d last", tag, c), 64'(out_last), 64'(c == 7));
    chk($sformatf("%s c%0d done", tag, c), 64'(done), 64'(0));
  endtask

  task automatic finish_pass(input string tag);
    chk($sformatf("%s done pulse", tag), 64'(done), 64'(1));
    chk($sformatf("%s done valid", tag), 64'(out_valid), 64'(0));
    tick();
    chk($sformatf("%s idle done", tag), 64'(done), 64'(0));
    chk($sformatf("%s idle busy", tag), 64'(busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cont = 1'b0; ss_we = 1'b0;
    ss_waddr = '0; ss_wdata = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    ident  = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    lanes8 = {5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8};

    repeat (2) tick();
    chk("rst valid", 64'(out_valid), 64'(0));
    chk("rst pkg", 64'(out_index_pkg), 64'(0));
    chk("rst cycle", 64'(out_cycle), 64'(0));
    chk("rst last", 64'(out_last), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst err", 64'(ss_wr_err), 64'(0));
    reset = 1'b0;
    tick();

    // T1: all-zero table, full-rate pass
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1 c0 ident", 64'(out_index_pkg), 64'(ident));
    for (int c = 0; c < 8; c++) begin
      chk_beat("t1", c);
      chk("t1 busy", 64'(busy), 64'(1));
      if (c == 5) chk("t1 c5 lanes", 64'(out_index_pkg), 64'(lanes8));
      tick();
    end
    finish_pass("t1");

    // T2: write ss[11]=2, then start together with write ss[0]=1
    ss_we = 1'b1; ss_waddr = 4'd11; ss_wdata = 2'd2; tab[11] = 2'd2;
    tick();
    ss_waddr = 4'd0; ss_wdata = 2'd1; tab[0] = 2'd1; start = 1'b1;
    tick();
    ss_we = 1'b0; start = 1'b0;
    chk("t2 c0 lane0 fwd", 64'(out_index_pkg[4:0]), 64'(8));
    for (int c = 0; c < 8; c++) begin
      chk_beat("t2", c);
      if (c == 1) chk("t2 c1 lane0", 64'(out_index_pkg[4:0]), 64'(16));
      if (c == 4) chk("t2 c4 lane3", 64'(out_index_pkg[19:15]), 64'(19));
      if (c == 6) chk("t2 c6 lane3", 64'(out_index_pkg[19:15]), 64'(3));
      if (c == 7) chk("t2 c7 lane3", 64'(out_index_pkg[19:15]), 64'(11));
      tick();
    end
    finish_pass("t2");

    // T3: backpressure while cycle 2 is presented
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t3", 0); tick();
    chk_beat("t3", 1); tick();
    chk_beat("t3", 2); out_ready = 1'b0; tick();
    chk_beat("t3 hold1", 2); tick();
    chk_beat("t3 hold2", 2); out_ready = 1'b1; tick();
    for (int c = 3; c < 8; c++) begin
      chk_beat("t3", c);
      tick();
    end
    finish_pass("t3");

    // T4: continuous mode for 20 beats, then drop cont
    cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_beat("t4 cont", i % 8);
      tick();
    end
    cont = 1'b0;
    for (int c = 4; c < 8; c++) begin
      chk_beat("t4 tail", c);
      tick();
    end
    finish_pass("t4");

    // T5: table write attempt during a pass is dropped and flagged
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_beat("t5", 0); tick();
    chk_beat("t5", 1); tick();
    chk_beat("t5", 2);
    ss_we = 1'b1; ss_waddr = 4'd11; ss_wdata = 2'd3;
    tick();
    ss_we = 1'b0;
    chk("t5 err pulse", 64'(ss_wr_err), 64'(1));
    for (int c = 3; c < 8; c++) begin
      chk_beat("t5", c);
      if (c == 4) chk("t5 err clear", 64'(ss_wr_err), 64'(0));
      tick();
    end
    finish_pass("t5");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk_beat("t5 next", c);
      if (c == 4) chk("t5 next c4 lane3", 64'(out_index_pkg[19:15]), 64'(19));
      tick();
    end
    finish_pass("t5 next");

    // T6: asynchronous reset mid-pass at cycle 3
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk_beat("t6", c);
      if (c < 3) tick();
    end
    reset = 1'b1;
    #1;
    chk("t6 rst valid", 64'(out_valid), 64'(0));
    chk("t6 rst cycle", 64'(out_cycle), 64'(0));
    chk("t6 rst pkg", 64'(out_index_pkg), 64'(0));
    chk("t6 rst busy", 64'(busy), 64'(0));
    chk("t6 rst last", 64'(out_last), 64'(0));
    for (int i = 0; i < 16; i++) tab[i] = '0;
    tick();
    chk("t6 rst no done", 64'(done), 64'(0));
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6 restart ident", 64'(out_index_pkg), 64'(ident));
    for (int c = 0; c < 8; c++) begin
      chk_beat("t6 restart", c);
      if (c == 4) chk("t6 cleared c4 lane3", 64'(out_index_pkg[19:15]), 64'(3));
      tick();
    end
    finish_pass("t6");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
